// File: rtl/mshr_merge_queue_pkg.sv
// rtl/mshr_merge_queue_pkg.sv - shared types and helpers for the MSHR merge queue
// Holds the bus command encoding, the per-entry status flags and the block compare.
package mshr_merge_queue_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    // Per-entry status bits; address/data/tag/parent widths are parametrised
    // and therefore live beside this struct in the slot.
    typedef struct packed {
        logic valid;
        logic is_store;
        logic issued;
        logic done;
        logic merged;
    } mshr_flags_t;

    localparam int unsigned ADDR_MAX_W = 64;

    // Two addresses hit the same cache block when they agree above the offset.
    function automatic logic same_block(input logic [ADDR_MAX_W-1:0] a,
                                        input logic [ADDR_MAX_W-1:0] b,
                                        input int unsigned blk_off);
        return (a >> blk_off) == (b >> blk_off);
    endfunction

endpackage

// File: rtl/mshr_merge_queue_if.sv
// rtl/mshr_merge_queue_if.sv - allocation, memory bus and retire signals of the MSHR queue
// slave modport: queue side; master modport: LSQ/bus/consumer side.
interface mshr_merge_queue_if
    import mshr_merge_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int XLEN      = 32,
    parameter int DATA_W    = 64,
    parameter int MEM_TAG_W = 4
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic                 alloc_is_store;
    logic [XLEN-1:0]      alloc_addr;
    logic [DATA_W-1:0]    alloc_data;
    logic [IDX_W-1:0]     alloc_idx;
    bus_cmd_e             proc2mem_command;
    logic [XLEN-1:0]      proc2mem_addr;
    logic [DATA_W-1:0]    proc2mem_data;
    logic [MEM_TAG_W-1:0] mem2proc_response;
    logic [MEM_TAG_W-1:0] mem2proc_tag;
    logic [DATA_W-1:0]    mem2proc_data;
    logic                 retire_valid;
    logic                 retire_ready;
    logic                 retire_is_store;
    logic [XLEN-1:0]      retire_addr;
    logic [DATA_W-1:0]    retire_data;
    logic [IDX_W-1:0]     retire_idx;
    logic                 full;
    logic                 empty;
    logic [IDX_W:0]       count;

    modport slave (
        input  alloc_valid, alloc_is_store, alloc_addr, alloc_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data, retire_ready,
        output alloc_ready, alloc_idx, proc2mem_command, proc2mem_addr, proc2mem_data,
        output retire_valid, retire_is_store, retire_addr, retire_data, retire_idx,
        output full, empty, count
    );

    modport master (
        output alloc_valid, alloc_is_store, alloc_addr, alloc_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data, retire_ready,
        input  alloc_ready, alloc_idx, proc2mem_command, proc2mem_addr, proc2mem_data,
        input  retire_valid, retire_is_store, retire_addr, retire_data, retire_idx,
        input  full, empty, count
    );

endinterface

// File: rtl/mshr_merge_queue_slot.sv
// rtl/mshr_merge_queue_slot.sv - one MSHR entry register with alloc/accept/fill/clear updates
// Inputs: alloc_* write a fresh entry, accept_* record bus acceptance, fill_* take returned
// data, clear_en frees the entry at retire. Outputs: current flags and fields.
module mshr_merge_queue_slot
    import mshr_merge_queue_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DATA_W    = 64,
    parameter int MEM_TAG_W = 4,
    parameter int IDX_W     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic                 alloc_is_store,
    input  logic [XLEN-1:0]      alloc_addr,
    input  logic [DATA_W-1:0]    alloc_data,
    input  logic                 alloc_merged,
    input  logic [IDX_W-1:0]     alloc_parent,
    input  logic                 alloc_done,
    input  logic                 accept_en,
    input  logic [MEM_TAG_W-1:0] accept_tag,
    input  logic                 fill_en,
    input  logic [DATA_W-1:0]    fill_data,
    input  logic                 clear_en,
    output mshr_flags_t          flags_o,
    output logic [XLEN-1:0]      addr_o,
    output logic [DATA_W-1:0]    data_o,
    output logic [MEM_TAG_W-1:0] tag_o,
    output logic [IDX_W-1:0]     parent_o
);
    mshr_flags_t          flags_q, flags_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [MEM_TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0]     parent_q, parent_d;

    // A slot is never allocated while it is still occupied, so alloc does not
    // collide with accept/fill/clear on the same slot.
    always_comb begin
        flags_d  = flags_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tag_d    = tag_q;
        parent_d = parent_q;
        if (clear_en) begin
            flags_d  = '0;
            addr_d   = '0;
            data_d   = '0;
            tag_d    = '0;
            parent_d = '0;
        end
        if (accept_en) begin
            flags_d.issued = 1'b1;
            if (flags_q.is_store) flags_d.done = 1'b1;
            else                  tag_d = accept_tag;
        end
        if (fill_en) begin
            data_d       = fill_data;
            flags_d.done = 1'b1;
        end
        if (alloc_en) begin
            flags_d.valid    = 1'b1;
            flags_d.is_store = alloc_is_store;
            flags_d.issued   = alloc_merged;
            flags_d.done     = alloc_done;
            flags_d.merged   = alloc_merged;
            addr_d           = alloc_addr;
            data_d           = alloc_data;
            tag_d            = '0;
            parent_d         = alloc_parent;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            parent_q <= '0;
        end else begin
            flags_q  <= flags_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            parent_q <= parent_d;
        end
    end

    assign flags_o  = flags_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign tag_o    = tag_q;
    assign parent_o = parent_q;

endmodule

// File: rtl/mshr_merge_queue.sv
// rtl/mshr_merge_queue.sv - in-order MSHR queue with secondary-miss merging
// Ports: clock, reset (async, active-high) and bus (slave modport) carrying the
// alloc handshake, memory bus request/response/fill, retire handshake and status.
module mshr_merge_queue
    import mshr_merge_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int XLEN      = 32,
    parameter int DATA_W    = 64,
    parameter int MEM_TAG_W = 4,
    parameter int BLK_OFF   = 3,
    parameter int MERGE_EN  = 1
) (
    input  logic               clock,
    input  logic               reset,
    mshr_merge_queue_if.slave  bus
);
    localparam int             IDX_W   = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0]     head_q, head_d, send_q, send_d, tail_q, tail_d;
    logic [IDX_W:0]       count_q, count_d;

    mshr_flags_t          flg      [DEPTH];
    logic [XLEN-1:0]      e_addr   [DEPTH];
    logic [DATA_W-1:0]    e_data   [DEPTH];
    logic [MEM_TAG_W-1:0] e_tag    [DEPTH];
    logic [IDX_W-1:0]     e_parent [DEPTH];

    logic [DEPTH-1:0]     fill_hit, fill_en, alloc_en, accept_en, clear_en;
    logic                 alloc_fire, accept_fire, retire_fire, send_skip;
    logic                 store_block, cam_hit, merge_hit, alloc_done;
    logic [IDX_W-1:0]     cam_idx;
    logic [DATA_W-1:0]    alloc_wdata;
    bus_cmd_e             cmd;

    // Primary fills: issued, unmerged, outstanding loads whose tag returns.
    always_comb begin
        fill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fill_hit[i] = (bus.mem2proc_tag != '0) && flg[i].valid && flg[i].issued &&
                          !flg[i].merged && !flg[i].is_store && !flg[i].done &&
                          (e_tag[i] == bus.mem2proc_tag);
        end
    end

    // Merged children complete on the same edge as their parent.
    always_comb begin
        fill_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fill_en[i] = fill_hit[i] ||
                         (flg[i].valid && flg[i].merged && !flg[i].done && fill_hit[e_parent[i]]);
        end
    end

    // Merge CAM: walk backwards from TAIL so the first qualifying entry is the youngest.
    // An outstanding store to the block disables merging to keep load/store order.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx         = '0;
        store_block = 1'b0;
        cam_hit     = 1'b0;
        cam_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flg[i].valid && flg[i].is_store && !flg[i].done &&
                same_block(64'(e_addr[i]), 64'(bus.alloc_addr), BLK_OFF))
                store_block = 1'b1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_q - IDX_W'(k + 1);
            if (!cam_hit && flg[idx].valid && !flg[idx].is_store && !flg[idx].merged &&
                !flg[idx].done && same_block(64'(e_addr[idx]), 64'(bus.alloc_addr), BLK_OFF)) begin
                cam_hit = 1'b1;
                cam_idx = idx;
            end
        end
        merge_hit   = (MERGE_EN != 0) && !bus.alloc_is_store && cam_hit && !store_block;
        alloc_done  = merge_hit && fill_hit[cam_idx];
        alloc_wdata = alloc_done ? bus.mem2proc_data :
                      (bus.alloc_is_store ? bus.alloc_data : '0);
    end

    // Issue, accept, retire and pointer/count updates.
    always_comb begin
        cmd       = BUS_NONE;
        send_skip = 1'b0;
        if (flg[send_q].valid) begin
            if (flg[send_q].merged)      send_skip = 1'b1;
            else if (!flg[send_q].issued) cmd = flg[send_q].is_store ? BUS_STORE : BUS_LOAD;
        end
        accept_fire = (cmd != BUS_NONE) && (bus.mem2proc_response != '0);
        retire_fire = flg[head_q].valid && flg[head_q].done && bus.retire_ready;
        alloc_fire  = bus.alloc_valid && (count_q != DEPTH_C);

        alloc_en  = '0;
        accept_en = '0;
        clear_en  = '0;
        if (alloc_fire)  alloc_en[tail_q]  = 1'b1;
        if (accept_fire) accept_en[send_q] = 1'b1;
        if (retire_fire) clear_en[head_q]  = 1'b1;

        tail_d  = alloc_fire ? tail_q + 1'b1 : tail_q;
        send_d  = (accept_fire || send_skip) ? send_q + 1'b1 : send_q;
        head_d  = retire_fire ? head_q + 1'b1 : head_q;
        count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(retire_fire);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            send_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            send_q  <= send_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        mshr_merge_queue_slot #(
            .XLEN(XLEN), .DATA_W(DATA_W), .MEM_TAG_W(MEM_TAG_W), .IDX_W(IDX_W)
        ) u_slot (
            .clock          (clock),
            .reset          (reset),
            .alloc_en       (alloc_en[i]),
            .alloc_is_store (bus.alloc_is_store),
            .alloc_addr     (bus.alloc_addr),
            .alloc_data     (alloc_wdata),
            .alloc_merged   (merge_hit),
            .alloc_parent   (merge_hit ? cam_idx : '0),
            .alloc_done     (alloc_done),
            .accept_en      (accept_en[i]),
            .accept_tag     (bus.mem2proc_response),
            .fill_en        (fill_en[i]),
            .fill_data      (bus.mem2proc_data),
            .clear_en       (clear_en[i]),
            .flags_o        (flg[i]),
            .addr_o         (e_addr[i]),
            .data_o         (e_data[i]),
            .tag_o          (e_tag[i]),
            .parent_o       (e_parent[i])
        );
    end

    assign bus.alloc_ready      = (count_q != DEPTH_C);
    assign bus.alloc_idx        = tail_q;
    assign bus.proc2mem_command = cmd;
    assign bus.proc2mem_addr    = (cmd != BUS_NONE) ? e_addr[send_q] : '0;
    assign bus.proc2mem_data    = (cmd != BUS_NONE) ? e_data[send_q] : '0;
    assign bus.retire_valid     = flg[head_q].valid && flg[head_q].done;
    assign bus.retire_is_store  = flg[head_q].is_store;
    assign bus.retire_addr      = e_addr[head_q];
    assign bus.retire_data      = e_data[head_q];
    assign bus.retire_idx       = head_q;
    assign bus.full             = (count_q == DEPTH_C);
    assign bus.empty            = (count_q == '0);
    assign bus.count            = count_q;

endmodule
